pll_clken_manager: RTL and testbench
====================================

// Module: pll_clken_manager
// PURPOSE
//  Sits behind a Gowin rPLL wrapper in the PLL output clock domain. It filters the PLL lock
//  output and sequences a reset release for downstream logic. Once running, it generates NCH
//  independent fractional-rate clock-enable strobes with phase accumulators, for example
//  7M/PHI0/CPU enables derived from one PLL clock.
// PARAMETERS
//  NCH        4       number of clock-enable channels (1..8)
//  ACC_W      24      phase accumulator width; strobe rate = f_clkin * INC / 2^ACC_W
//  INC_INIT   {NCH{24'h100000}}  packed NCH*ACC_W increments, channel i at [i*ACC_W +: ACC_W]
//  LOCK_FILT  1024    consecutive synchronised-lock-high cycles required before lock is trusted
//  RST_HOLD   16      cycles rst_out stays asserted after lock is trusted
// PORTS
//  clkin      in   1          PLL output clock; the single clock of this block
//  reset      in   1          asynchronous, active-high reset
//  lock       in   1          raw PLL LOCK; asynchronous to clkin, 2-FF synchronised inside
//  rst_out    out  1          active-high synchronous reset to downstream logic
//  locked     out  1          filtered lock status
//  ce         out  NCH        one-cycle clock-enable strobes, registered
//  inc_wr     in   1          [DYN_INC_EN only] increment write strobe
//  inc_sel    in   3          [DYN_INC_EN only] channel index for the write
//  inc_data   in   ACC_W      [DYN_INC_EN only] new increment value
// BEHAVIOUR
//  Reset: asynchronous, active-high. While reset is high: rst_out=1, locked=0, ce=0,
//   accumulators=0, sync FFs=0, counters=0, FSM=WAIT, increments=INC_INIT.
//  lock_s: lock passed through a 2-FF synchroniser; 2-cycle latency.
//  FSM states and transitions:
//   WAIT   lock_s=1 -> FILT; the filter count starts at 1.
//   FILT   count increments while lock_s=1; count==LOCK_FILT -> HOLD with locked=1;
//          lock_s=0 -> WAIT with count=0.
//   HOLD   hold count increments; count==RST_HOLD -> RUN with rst_out=0;
//          lock_s=0 -> WAIT.
//   RUN    accumulators advance; lock_s=0 -> WAIT.
//  Timing: with lock held high from clkin edge E, rst_out falls at edge
//   E+2+LOCK_FILT+RST_HOLD. Leaving any state for WAIT on lock loss sets locked=0 and
//   rst_out=1 on the next edge.
//  Accumulators, RUN only: {carry,acc[i]} <= acc[i] + inc[i], ACC_W+1-bit sum.
//   ce[i] <= carry, registered, so ce is high the cycle after the wrapping add. Wrap-around
//   is modulo 2^ACC_W; the remainder is kept, so there is no drift.
//  Accumulators outside RUN: acc=0 and ce=0. The first strobe comes ceil(2^ACC_W/inc)
//   RUN cycles after entry.
//  inc=0 gives ce never high. inc >= 2^(ACC_W-1) gives a strobe on at least every other
//   cycle. The maximum inc (all ones) gives ce high on all but one cycle per 2^ACC_W.
//  ce is never high while rst_out=1.
// CONFIGURATION
//  Macro PLL_CLKEN_DYN_INC_EN:
//   Defined: the inc_wr, inc_sel and inc_data ports exist. A write takes effect on the add
//    in the next cycle; the accumulator is not cleared.
//   Writes with inc_sel >= NCH are ignored.
//   Write during reset: ignored.
//   Write and lock loss in the same cycle: the new increment is kept; the accumulator clears.
//   Undefined: the ports are absent and the increments are the constants INC_INIT.
// TESTING
//  T1 ACC_W=8, LOCK_FILT=8, RST_HOLD=4, lock=1 from edge 10:
//   locked rises at edge 20 and rst_out falls at edge 24.
//  T2 lock pulses high for 5 cycles, then low, then high:
//   the FSM returns to WAIT, the filter restarts from 1, and rst_out stays 1 until the
//   full sequence completes.
//  T3 in RUN, inc={8'd64, 8'd3, 8'd0, 8'd255}:
//   ce[0] strobes every 4 cycles; ce[1] strobes 3 times per 256 cycles;
//   ce[2] never strobes; ce[3] strobes 255 times per 256 cycles.
//  T4 lock drops for 1 cycle mid-RUN:
//   after the 2-cycle sync latency, rst_out=1 and ce=0 on the next edge, with all
//   accumulators at 0; lock recovers through the full filter.
//  T5 reset asserted asynchronously mid-RUN, between clock edges:
//   all outputs take their reset values immediately, with no clock edge required.
//  T6 (DYN_INC_EN) write inc_sel=1, inc_data=128 while ce[1] is at 3/256:
//   ce[1] becomes every 2 cycles within 2 cycles; a write with inc_sel=7 and NCH=4 has
//   no effect.

Source files
------------

// File: rtl/pll_clken_manager.sv
// ---------------------------------------------------------------------------
// pll_clken_manager
//
// Purpose:
//   Lives in the PLL output clock domain behind a Gowin rPLL wrapper. It
//   synchronises and filters the raw PLL lock, sequences the release of a
//   downstream synchronous reset, and, once running, produces NCH independent
//   fractional-rate clock-enable strobes from phase accumulators
//   (strobe rate = f_clkin * INC / 2^ACC_W).
//
// Optional feature macro:
//   PLL_CLKEN_DYN_INC_EN - adds the inc_wr/inc_sel/inc_data write port so
//   channel increments can be changed at run time. When undefined, the
//   increments are the constants in INC_INIT.
//
// Ports:
//   clkin     in   1      PLL output clock, the only clock of this block
//   reset     in   1      asynchronous active-high reset
//   lock      in   1      raw PLL LOCK, asynchronous, 2-FF synchronised here
//   inc_wr    in   1      increment write strobe        (macro only)
//   inc_sel   in   3      channel index for the write   (macro only)
//   inc_data  in   ACC_W  new increment value           (macro only)
//   rst_out   out  1      active-high synchronous reset for downstream logic
//   locked    out  1      filtered lock status
//   ce        out  NCH    one-cycle clock-enable strobes, registered
// ---------------------------------------------------------------------------
module pll_clken_manager #(
  parameter int                   NCH       = 4,
  parameter int                   ACC_W     = 24,
  parameter logic [NCH*ACC_W-1:0] INC_INIT  = {NCH{24'h100000}},
  parameter int                   LOCK_FILT = 1024,
  parameter int                   RST_HOLD  = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             lock,
`ifdef PLL_CLKEN_DYN_INC_EN
  input  logic             inc_wr,
  input  logic [2:0]       inc_sel,
  input  logic [ACC_W-1:0] inc_data,
`endif
  output logic             rst_out,
  output logic             locked,
  output logic [NCH-1:0]   ce
);

  // One counter serves both the lock filter and the reset hold, so it must
  // reach the larger of the two terminal counts.
  localparam int CNT_MAX = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILT);
  localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(RST_HOLD);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_FILT,
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sync1_reg;
  logic             lock_s;
  logic             locked_reg;
  logic             rst_out_reg;
  logic             run_adv;

  // 2-FF synchroniser for the asynchronous lock input.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      sync1_reg <= lock;
      lock_s    <= sync1_reg;
    end
  end

  // Lock filter / reset sequencer. Both counts start at 1 on entry so that
  // the terminal compare happens exactly LOCK_FILT (RST_HOLD) edges later.
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_WAIT;
      cnt_reg     <= '0;
      locked_reg  <= 1'b0;
      rst_out_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (lock_s) begin
            state_reg <= ST_FILT;
            cnt_reg   <= CNT_W'(1);
          end
        end
        ST_FILT: begin
          if (!lock_s) begin
            state_reg <= ST_WAIT;
            cnt_reg   <= '0;
          end else if (cnt_reg == FILT_END) begin
            state_reg  <= ST_HOLD;
            cnt_reg    <= CNT_W'(1);
            locked_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!lock_s) begin
            state_reg   <= ST_WAIT;
            cnt_reg     <= '0;
            locked_reg  <= 1'b0;
            rst_out_reg <= 1'b1;
          end else if (cnt_reg == HOLD_END) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            rst_out_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin  // ST_RUN
          if (!lock_s) begin
            state_reg   <= ST_WAIT;
            cnt_reg     <= '0;
            locked_reg  <= 1'b0;
            rst_out_reg <= 1'b1;
          end
        end
      endcase
    end
  end

  assign rst_out = rst_out_reg;
  assign locked  = locked_reg;

  // Accumulators only advance on edges where the FSM is in RUN and stays
  // there; the lock-loss edge clears them together with ce, so ce can never
  // be high while rst_out is high.
  assign run_adv = (state_reg == ST_RUN) && lock_s;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] inc_val;
      logic [ACC_W:0]   sum;
      logic             ce_reg;

`ifdef PLL_CLKEN_DYN_INC_EN
      // Matching on the full 3-bit index makes out-of-range selects a no-op.
      // The accumulator is untouched, so a rate change keeps the phase.
      always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
          inc_val <= INC_INIT[gi*ACC_W +: ACC_W];
        end else if (inc_wr && (inc_sel == 3'(gi))) begin
          inc_val <= inc_data;
        end
      end
`else
      assign inc_val = INC_INIT[gi*ACC_W +: ACC_W];
`endif

      // Carry out of the ACC_W+1 bit sum is the strobe; the remainder stays
      // in the accumulator, so the long-term rate is exact.
      assign sum = {1'b0, acc_reg} + {1'b0, inc_val};

      always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
          acc_reg <= '0;
          ce_reg  <= 1'b0;
        end else if (run_adv) begin
          acc_reg <= sum[ACC_W-1:0];
          ce_reg  <= sum[ACC_W];
        end else begin
          acc_reg <= '0;
          ce_reg  <= 1'b0;
        end
      end

      assign ce[gi] = ce_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pll_clken_manager.sv
// ---------------------------------------------------------------------------
// tb_pll_clken_manager
//
// Self-checking bench. The reference model works from the lock history only:
// lock_s is the lock input delayed by two edges, the FSM outputs follow from
// the length of the current unbroken run of lock_s highs, and each ce bit is
// the change of floor(k*inc/2^ACC_W) after k RUN-edge additions.
// ---------------------------------------------------------------------------
module tb_pll_clken_manager;

  localparam int NCH   = 4;
  localparam int ACC_W = 8;
  localparam int LF    = 8;
  localparam int RH    = 4;
  localparam logic [NCH*ACC_W-1:0] INC_P = {8'd255, 8'd0, 8'd3, 8'd64};

  logic           clkin = 1'b0;
  logic           reset = 1'b1;
  logic           lock  = 1'b0;
  logic           rst_out;
  logic           locked;
  logic [NCH-1:0] ce;
`ifdef PLL_CLKEN_DYN_INC_EN
  logic             inc_wr   = 1'b0;
  logic [2:0]       inc_sel  = 3'd0;
  logic [ACC_W-1:0] inc_data = '0;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int run_len  = 0;
  bit model_on = 1'b1;
  int inc_m[NCH] = '{64, 3, 0, 255};
  logic lq[$];

  pll_clken_manager #(
    .NCH      (NCH),
    .ACC_W    (ACC_W),
    .INC_INIT (INC_P),
    .LOCK_FILT(LF),
    .RST_HOLD (RH)
  ) dut (
    .clkin   (clkin),
    .reset   (reset),
    .lock    (lock),
`ifdef PLL_CLKEN_DYN_INC_EN
    .inc_wr  (inc_wr),
    .inc_sel (inc_sel),
    .inc_data(inc_data),
`endif
    .rst_out (rst_out),
    .locked  (locked),
    .ce      (ce)
  );

  always #5 clkin = ~clkin;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic reset_model();
    lq.delete();
    run_len = 0;
    cyc     = 0;
  endtask

  // Advance the model by one edge with lock value lk present at that edge,
  // then compare against the DUT outputs.
  task automatic model_edge(input logic lk);
    logic           v;
    int             k;
    logic [NCH-1:0] exp_ce;
    lq.push_back(lk);
    if (lq.size() > 2) v = lq.pop_front();
    else v = 1'b0;
    run_len = v ? run_len + 1 : 0;
    k = run_len - (LF + RH + 1);
    exp_ce = '0;
    for (int i = 0; i < NCH; i++) begin
      if (k >= 1)
        exp_ce[i] = (((k * inc_m[i]) >> ACC_W) - (((k - 1) * inc_m[i]) >> ACC_W)) != 0;
    end
    if (model_on) begin
      check_val("locked", 32'(locked), 32'(run_len >= LF + 1));
      check_val("rst_out", 32'(rst_out), 32'(run_len < LF + RH + 1));
      check_val("ce", 32'(ce), 32'(exp_ce));
    end
  endtask

  task automatic step(input logic lk);
    lock = lk;
    @(posedge clkin);
    #1;
    cyc++;
    model_edge(lk);
  endtask

  task automatic release_reset();
    lock = 1'b0;
    @(posedge clkin);
    #2;
    reset = 1'b0;
    reset_model();
  endtask

  int hi, lo;
  int cnt[NCH];
  logic a1, a2;

  initial begin
    // Reset state
    repeat (3) @(posedge clkin);
    #1;
    check_val("reset_rst_out", 32'(rst_out), 32'd1);
    check_val("reset_locked", 32'(locked), 32'd0);
    check_val("reset_ce", 32'(ce), 32'd0);
    release_reset();

    // T1: lock high from edge 10
    for (int e = 1; e <= 40; e++) begin
      step(e >= 10);
      if (e == 19) check_val("t1_locked_19", 32'(locked), 32'd0);
      if (e == 20) check_val("t1_locked_20", 32'(locked), 32'd1);
      if (e == 23) check_val("t1_rst_23", 32'(rst_out), 32'd1);
      if (e == 24) check_val("t1_rst_24", 32'(rst_out), 32'd0);
    end

    // T3: strobe counts over 256 RUN cycles
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int n = 0; n < 256; n++) begin
      step(1'b1);
      for (int i = 0; i < NCH; i++) cnt[i] += int'(ce[i]);
    end
    check_val("t3_cnt0", 32'(cnt[0]), 32'd64);
    check_val("t3_cnt1", 32'(cnt[1]), 32'd3);
    check_val("t3_cnt2", 32'(cnt[2]), 32'd0);
    check_val("t3_cnt3", 32'(cnt[3]), 32'd255);

    // T4: one-cycle lock drop mid-RUN
    step(1'b0);
    step(1'b1);
    check_val("t4_rst_before", 32'(rst_out), 32'd0);
    step(1'b1);
    check_val("t4_rst_after", 32'(rst_out), 32'd1);
    check_val("t4_ce_after", 32'(ce), 32'd0);
    check_val("t4_locked_after", 32'(locked), 32'd0);
    repeat (40) step(1'b1);

    // T2: short pulse, drop, then full sequence
    repeat (3) step(1'b0);
    repeat (5) step(1'b1);
    repeat (3) step(1'b0);
    check_val("t2_locked_low", 32'(locked), 32'd0);
    repeat (12) step(1'b1);
    check_val("t2_rst_held", 32'(rst_out), 32'd1);
    repeat (20) step(1'b1);

    // Randomised lock patterns
    for (int s = 0; s < 60; s++) begin
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : int'($urandom_range(15, 60));
      lo = int'($urandom_range(1, 4));
      repeat (hi) step(1'b1);
      repeat (lo) step(1'b0);
    end

    // T5: asynchronous reset between edges while in RUN
    repeat (30) step(1'b1);
    check_val("t5_in_run", 32'(rst_out), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_rst_out", 32'(rst_out), 32'd1);
    check_val("t5_locked", 32'(locked), 32'd0);
    check_val("t5_ce", 32'(ce), 32'd0);
    release_reset();
    repeat (30) step(1'b1);

`ifdef PLL_CLKEN_DYN_INC_EN
    // T6: run-time increment writes
    model_on = 1'b0;
    inc_wr   = 1'b1;
    inc_sel  = 3'd1;
    inc_data = 8'd128;
    step(1'b1);
    inc_wr = 1'b0;
    step(1'b1);
    a1 = ce[1];
    step(1'b1);
    a2 = ce[1];
    check_val("t6_alternate", 32'(a1 ^ a2), 32'd1);
    cnt[1] = 0;
    for (int n = 0; n < 8; n++) begin
      step(1'b1);
      cnt[1] += int'(ce[1]);
    end
    check_val("t6_cnt1_8", 32'(cnt[1]), 32'd4);
    inc_wr   = 1'b1;
    inc_sel  = 3'd7;
    inc_data = 8'd0;
    step(1'b1);
    inc_wr = 1'b0;
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int n = 0; n < 256; n++) begin
      step(1'b1);
      for (int i = 0; i < NCH; i++) cnt[i] += int'(ce[i]);
    end
    check_val("t6_cnt0", 32'(cnt[0]), 32'd64);
    check_val("t6_cnt1", 32'(cnt[1]), 32'd128);
    check_val("t6_cnt2", 32'(cnt[2]), 32'd0);
    check_val("t6_cnt3", 32'(cnt[3]), 32'd255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
